// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents:
//   INSTR_W        - width of an instruction word
//   fetch_state_t  - fetch sequencer states
//   align_word()   - clears the byte-offset bits of an address
package fetch_unit_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register for the fetch unit.
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset, loads RESET_PC
//   load_i       - load a redirect target (takes priority over inc_i)
//   load_addr_i  - redirect target, forced word aligned
//   inc_i        - advance by one instruction (modulo 2^32)
//   pc_o         - current fetch address
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] load_addr_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = align_word(load_addr_i);
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time to instruction
// memory, captures the returned word into the IF/ID register and handles
// stalls (freeze) and redirects (branch_taken).
// Ports:
//   clk, rst_n                 - clock and async active-low reset
//   freeze                     - stall: holds IF/ID and the PC advance
//   branch_taken, branch_addr  - one-cycle redirect request and target
//   imem_req, imem_addr        - request and word-aligned address
//   imem_gnt                   - request accepted this cycle
//   imem_rvalid, imem_rdata    - in-order read response
//   if_valid, if_pc, if_instr  - IF/ID register contents
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_t        state_q, state_d;
  logic                kill_q, kill_d;
  logic [INSTR_W-1:0]  buf_q, buf_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_pc_q, if_pc_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;

  logic                pc_load, pc_inc;
  logic [31:0]         pc;
  logic                deliver;
  logic [INSTR_W-1:0]  deliver_data;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (pc_load),
    .load_addr_i (branch_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  // Sequencer. kill marks a granted request whose response must be
  // dropped because a redirect overtook it.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    buf_d        = buf_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    deliver      = 1'b0;
    deliver_data = buf_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          if (imem_gnt) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          if (imem_rvalid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (freeze) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_data = imem_rdata;
            pc_inc       = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          buf_d   = '0;
          state_d = REQ;
        end else if (!freeze) begin
          deliver      = 1'b1;
          deliver_data = buf_q;
          pc_inc       = 1'b1;
          state_d      = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // IF/ID register: flush beats freeze, freeze beats a new delivery,
  // and with nothing delivered the register becomes a bubble.
  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (branch_taken) begin
      if_valid_d = 1'b0;
    end else if (!freeze) begin
      if (deliver) begin
        if_valid_d = 1'b1;
        if_pc_d    = pc;
        if_instr_d = deliver_data;
      end else begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      buf_q      <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      buf_q      <= buf_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model of the
// fetch behaviour compared every cycle, plus hand-computed checkpoints.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imemReq, ifValid;
  logic [31:0] imemAddr, ifPc, ifInstr;
  logic        imemReqHi, ifValidHi;
  logic [31:0] imemAddrHi, ifPcHi, ifInstrHi;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  // Clock: 10 time-unit period
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(ifValid), .if_pc(ifPc), .if_instr(ifInstr)
  );

  // Second instance near the top of the address space, used for wrap
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutHi (
    .clk(clk), .rst_n(rst_n), .freeze(freeze),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .imem_req(imemReqHi), .imem_addr(imemAddrHi), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(ifValidHi), .if_pc(ifPcHi), .if_instr(ifInstrHi)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Transaction model: the next address to fetch, whether a request is
  // outstanding (and whether its answer is already doomed), whether an
  // answer is parked waiting for the stall to end, and the IF/ID view.
  logic [31:0] mPc = 32'h0;
  bit          mStarted = 1'b0;
  bit          mBusy = 1'b0;
  bit          mDead = 1'b0;
  bit          mParked = 1'b0;
  logic [31:0] mParkData = '0;
  bit          expValid = 1'b0;
  logic [31:0] expPc = '0;
  logic [31:0] expInstr = '0;

  always @(posedge clk or negedge rst_n) begin : modelStep
    bit          got;
    logic [31:0] gotPc, gotData, target;
    if (!rst_n) begin
      mPc = 32'h0; mStarted = 1'b0; mBusy = 1'b0; mDead = 1'b0;
      mParked = 1'b0; mParkData = '0;
      expValid = 1'b0; expPc = '0; expInstr = '0;
    end else begin
      got = 1'b0; gotPc = mPc; gotData = '0;
      target = {branch_addr[31:2], 2'b00};
      if (!mStarted) begin
        mStarted = 1'b1;
      end else if (mParked) begin
        if (branch_taken) begin
          mParked = 1'b0;
          mPc = target;
        end else if (!freeze) begin
          got = 1'b1; gotData = mParkData;
          mParked = 1'b0;
          mPc = mPc + 32'd4;
        end
      end else if (mBusy) begin
        if (imem_rvalid) begin
          mBusy = 1'b0;
          if (!mDead && !branch_taken) begin
            if (freeze) begin
              mParked = 1'b1; mParkData = imem_rdata;
            end else begin
              got = 1'b1; gotData = imem_rdata;
              mPc = mPc + 32'd4;
            end
          end
          mDead = 1'b0;
        end else if (branch_taken) begin
          mDead = 1'b1;
        end
        if (branch_taken) mPc = target;
      end else begin
        if (imem_gnt) begin
          mBusy = 1'b1;
          mDead = branch_taken;
        end
        if (branch_taken) mPc = target;
      end
      if (branch_taken) expValid = 1'b0;
      else if (!freeze) begin
        if (got) begin
          expValid = 1'b1; expPc = gotPc; expInstr = gotData;
        end else begin
          expValid = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_if_valid", {31'b0, ifValid}, {31'b0, expValid});
      checkOutput("cyc_if_pc", ifPc, expPc);
      checkOutput("cyc_if_instr", ifInstr, expInstr);
      checkOutput("cyc_imem_req", {31'b0, imemReq},
                  {31'b0, mStarted && !mBusy && !mParked});
      checkOutput("cyc_imem_addr", imemAddr, mPc);
    end
  end

  // Drive one cycle of inputs, then return shortly after the rising edge
  task automatic applyStimulus(input bit fr, input bit br, input logic [31:0] ba,
                               input bit gnt, input bit rv, input logic [31:0] rd);
    freeze = fr; branch_taken = br; branch_addr = ba;
    imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cmpEn = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_if_valid", {31'b0, ifValid}, 32'h0);
    checkOutput("rst_if_pc", ifPc, 32'h0);
    checkOutput("rst_imem_req", {31'b0, imemReq}, 32'h0);
    checkOutput("rst_imem_addr_hi", imemAddrHi, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // First fetch with a zero-wait memory
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("first_req", {31'b0, imemReq}, 32'h1);
    checkOutput("first_addr", imemAddr, 32'h0);
    checkOutput("hi_first_addr", imemAddrHi, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait_no_req", {31'b0, imemReq}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1111_0000);
    checkOutput("first_valid", {31'b0, ifValid}, 32'h1);
    checkOutput("first_pc", ifPc, 32'h0);
    checkOutput("first_instr", ifInstr, 32'h1111_0000);
    checkOutput("next_addr", imemAddr, 32'h4);
    checkOutput("hi_if_pc", ifPcHi, 32'hFFFF_FFFC);
    checkOutput("hi_wrap_addr", imemAddrHi, 32'h0);

    // Second fetch leaves pc at 8
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h2222_0004);
    checkOutput("second_pc", ifPc, 32'h4);

    // Freeze across the response: IF/ID holds, data parks until release
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'hAAAA_5555);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("frz_valid", {31'b0, ifValid}, 32'h1);
    checkOutput("frz_pc", ifPc, 32'h4);
    checkOutput("frz_instr", ifInstr, 32'h2222_0004);
    checkOutput("frz_req", {31'b0, imemReq}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("unfrz_pc", ifPc, 32'h8);
    checkOutput("unfrz_instr", ifInstr, 32'hAAAA_5555);
    checkOutput("unfrz_addr", imemAddr, 32'hC);

    // Redirect while waiting; the late response is dropped
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 32'h40, 0, 0, 0);
    checkOutput("br_flush", {31'b0, ifValid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("br_drop_valid", {31'b0, ifValid}, 32'h0);
    checkOutput("br_new_addr", imemAddr, 32'h40);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h4040_4040);
    checkOutput("br_target_pc", ifPc, 32'h40);

    // Redirect and freeze together: flush wins, target is aligned
    applyStimulus(1, 1, 32'h103, 0, 0, 0);
    checkOutput("brfrz_valid", {31'b0, ifValid}, 32'h0);
    checkOutput("brfrz_addr", imemAddr, 32'h100);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h1000_0100);
    checkOutput("brfrz_pc", ifPc, 32'h100);

    // Response outside WAIT is ignored
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0001);
    checkOutput("stray_addr", imemAddr, 32'h104);

    // Redirect granted in the same cycle: that response is killed
    applyStimulus(0, 1, 32'h200, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0002);
    checkOutput("killgnt_valid", {31'b0, ifValid}, 32'h0);
    checkOutput("killgnt_addr", imemAddr, 32'h200);

    // Redirect while a response is parked
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h2000_0200);
    applyStimulus(1, 1, 32'h300, 0, 0, 0);
    checkOutput("hold_br_addr", imemAddr, 32'h300);
    checkOutput("hold_br_valid", {31'b0, ifValid}, 32'h0);

    // Reset pulse mid-transaction, stale responses afterwards
    applyStimulus(0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {31'b0, imemReq}, 32'h0);
    checkOutput("midrst_addr", imemAddr, 32'h0);
    checkOutput("midrst_pc", ifPc, 32'h0);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0003);
    applyStimulus(0, 0, 0, 0, 1, 32'hBAD0_0004);
    checkOutput("postrst_valid", {31'b0, ifValid}, 32'h0);
    checkOutput("postrst_addr", imemAddr, 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h5555_0000);
    checkOutput("postrst_pc", ifPc, 32'h0);
    checkOutput("postrst_instr", ifInstr, 32'h5555_0000);

    applyStimulus(0, 0, 0, 0, 0, 0);
    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
